// File: rtl/except_collect.sv
// EX->MEM exception collector: prioritises raw exception flags into a one-hot
// excepttype for CP0 and sequences the pipeline flush that follows an exception/eret.
module except_collect (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_is_branch,
  input  logic        ex_overflow,
  input  logic        ex_syscall,
  input  logic        ex_break,
  input  logic        ex_invalid,
  input  logic        ex_eret,
  input  logic        ex_mfc0,
  input  logic        ex_mtc0,
  input  logic [4:0]  ex_cp0_addr,
  input  logic        ex_mem_en,
  input  logic        ex_mem_we,
  input  logic [1:0]  ex_mem_size,
  input  logic [31:0] ex_mem_addr,
  output logic [13:0] excepttype,
  output logic [31:0] current_pc,
  output logic [31:0] bad_vaddr,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic        flush_req
);

  typedef enum logic [1:0] {RUN, FLUSH, DRAIN} state_t;

  state_t      r_state, w_state_nxt;
  logic [13:0] r_exc;
  logic [31:0] r_pc, r_badva;
  logic        r_mem_en, r_mem_we, r_ds;

  logic        w_fetch_ae, w_data_ae;
  logic        w_addr, w_ovf, w_sys, w_brk, w_inv, w_kill_in;
  logic [13:0] w_exc_nxt;
  logic [31:0] w_badva_nxt;
  logic        w_mem_kill, w_clear, w_load;

  // Exception or eret currently sitting in MEM
  assign w_mem_kill = |r_exc[7:2];

  assign w_fetch_ae = ex_pc[1:0] != 2'b00;
  assign w_data_ae  = ex_mem_en &&
                      ((ex_mem_size == 2'b01 && ex_mem_addr[0]) ||
                       (ex_mem_size == 2'b10 && ex_mem_addr[1:0] != 2'b00));

  always_comb begin
    w_addr = 1'b0; w_ovf = 1'b0; w_sys = 1'b0; w_brk = 1'b0; w_inv = 1'b0;
    w_badva_nxt = 32'd0;
    if (ex_valid) begin
      if (w_fetch_ae || w_data_ae) begin
        w_addr      = 1'b1;
        w_badva_nxt = w_fetch_ae ? ex_pc : ex_mem_addr;
      end
      else if (ex_overflow) w_ovf = 1'b1;
      else if (ex_syscall)  w_sys = 1'b1;
      else if (ex_break)    w_brk = 1'b1;
      else if (ex_invalid)  w_inv = 1'b1;
    end
  end

  assign w_kill_in = w_addr | w_ovf | w_sys | w_brk | w_inv | (ex_valid & ex_eret);

  assign w_exc_nxt = ex_valid ?
    {ex_cp0_addr, r_ds, w_addr, w_ovf, w_sys, w_brk, w_inv, ex_eret,
     ex_mfc0 & ~w_kill_in, ex_mtc0 & ~w_kill_in} : 14'd0;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  // Next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_mem_kill) w_state_nxt = FLUSH;
      FLUSH:   w_state_nxt = DRAIN;
      DRAIN:   w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // Outputs/controls; an excepting MEM instruction overrides stall so it shows for one cycle only
  always_comb begin
    flush_req = (r_state == FLUSH);
    w_clear   = (r_state != RUN) || w_mem_kill;
    w_load    = !w_clear && !stall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_exc    <= '0;
      r_pc     <= '0;
      r_badva  <= '0;
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      r_ds     <= 1'b0;
    end
    else if (w_clear) begin
      r_exc    <= '0;
      r_badva  <= '0;
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      r_ds     <= 1'b0;
    end
    else if (w_load) begin
      r_exc    <= w_exc_nxt;
      r_badva  <= w_badva_nxt;
      r_mem_en <= ex_valid & ex_mem_en & ~w_kill_in;
      r_mem_we <= ex_valid & ex_mem_we & ~w_kill_in;
      if (ex_valid) begin
        r_pc <= ex_pc;
        r_ds <= ex_is_branch;
      end
    end
  end

  assign excepttype = r_exc;
  assign current_pc = r_pc;
  assign bad_vaddr  = r_badva;
  assign mem_en_o   = r_mem_en;
  assign mem_we_o   = r_mem_we;

endmodule

// File: tb/tb_except_collect.sv
// Directed-vector bench for except_collect; expected values are hand-computed.
module tb_except_collect;

  logic        clk = 1'b0;
  logic        rst, stall, ex_valid, ex_is_branch;
  logic [31:0] ex_pc, ex_mem_addr;
  logic        ex_overflow, ex_syscall, ex_break, ex_invalid;
  logic        ex_eret, ex_mfc0, ex_mtc0, ex_mem_en, ex_mem_we;
  logic [4:0]  ex_cp0_addr;
  logic [1:0]  ex_mem_size;
  logic [13:0] excepttype;
  logic [31:0] current_pc, bad_vaddr;
  logic        mem_en_o, mem_we_o, flush_req;

  int n_vec = 0;
  int n_bad = 0;

  except_collect dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_is_branch(ex_is_branch), .ex_overflow(ex_overflow), .ex_syscall(ex_syscall),
    .ex_break(ex_break), .ex_invalid(ex_invalid), .ex_eret(ex_eret), .ex_mfc0(ex_mfc0),
    .ex_mtc0(ex_mtc0), .ex_cp0_addr(ex_cp0_addr), .ex_mem_en(ex_mem_en),
    .ex_mem_we(ex_mem_we), .ex_mem_size(ex_mem_size), .ex_mem_addr(ex_mem_addr),
    .excepttype(excepttype), .current_pc(current_pc), .bad_vaddr(bad_vaddr),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .flush_req(flush_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_idle();
    ex_valid = 0; ex_pc = 32'h0; ex_is_branch = 0;
    ex_overflow = 0; ex_syscall = 0; ex_break = 0; ex_invalid = 0;
    ex_eret = 0; ex_mfc0 = 0; ex_mtc0 = 0; ex_cp0_addr = 5'd0;
    ex_mem_en = 0; ex_mem_we = 0; ex_mem_size = 2'b00; ex_mem_addr = 32'h0;
  endtask

  task automatic ex_insn(input logic [31:0] pc);
    ex_idle();
    ex_valid = 1; ex_pc = pc;
  endtask

  // Walk FLUSH/DRAIN/bubble after an exception is visible, checking the pulse
  task automatic drain(input string tag, input logic [31:0] held_pc);
    ex_insn(32'h8000_0F00); ex_mfc0 = 1;
    step(); chk({tag, ".flush"}, flush_req, 1); chk({tag, ".exc_f"}, excepttype, 0);
    ex_insn(32'h8000_0F04); ex_mem_en = 1; ex_mem_size = 2'b10;
    step(); chk({tag, ".drain"}, flush_req, 0); chk({tag, ".men_d"}, mem_en_o, 0);
    ex_insn(32'h8000_0F08);
    step(); chk({tag, ".pc_held"}, current_pc, held_pc); chk({tag, ".exc_r"}, excepttype, 0);
    ex_idle();
  endtask

  initial begin
    rst = 1; stall = 0; ex_idle();
    step(); step();
    chk("rst.exc", excepttype, 0); chk("rst.pc", current_pc, 0);
    chk("rst.bva", bad_vaddr, 0);  chk("rst.men", mem_en_o, 0);
    chk("rst.mwe", mem_we_o, 0);   chk("rst.flush", flush_req, 0);
    rst = 0;

    // Aligned word store
    ex_insn(32'h8000_0000); ex_mem_en = 1; ex_mem_we = 1; ex_mem_size = 2'b10;
    ex_mem_addr = 32'h8000_1000;
    step();
    chk("st.exc", excepttype, 0); chk("st.pc", current_pc, 32'h8000_0000);
    chk("st.men", mem_en_o, 1);   chk("st.mwe", mem_we_o, 1); chk("st.bva", bad_vaddr, 0);

    // Byte load at odd address is legal
    ex_insn(32'h8000_0004); ex_mem_en = 1; ex_mem_size = 2'b00; ex_mem_addr = 32'h8000_1003;
    step();
    chk("lb.exc", excepttype, 0); chk("lb.men", mem_en_o, 1); chk("lb.mwe", mem_we_o, 0);

    // Misaligned word load
    ex_insn(32'h8000_0010); ex_mem_en = 1; ex_mem_size = 2'b10; ex_mem_addr = 32'h8000_1002;
    step();
    chk("lw.exc", excepttype, 14'h0080); chk("lw.bva", bad_vaddr, 32'h8000_1002);
    chk("lw.men", mem_en_o, 0);          chk("lw.flush", flush_req, 0);
    drain("lw", 32'h8000_0010);
    ex_insn(32'h8000_0180);
    step(); chk("lw.resume", current_pc, 32'h8000_0180);

    // Fetch and data faults together: fetch wins
    ex_insn(32'h8000_0202); ex_mem_en = 1; ex_mem_size = 2'b01; ex_mem_addr = 32'h8000_2001;
    step();
    chk("fa.exc", excepttype, 14'h0080); chk("fa.bva", bad_vaddr, 32'h8000_0202);
    drain("fa", 32'h8000_0202);

    // Branch, bubble, then syscall in the delay slot
    ex_insn(32'h8000_0100); ex_is_branch = 1;
    step(); chk("br.exc", excepttype, 0); chk("br.pc", current_pc, 32'h8000_0100);
    ex_idle();
    step(); chk("bub.exc", excepttype, 0); chk("bub.pc", current_pc, 32'h8000_0100);
    ex_insn(32'h8000_0104); ex_syscall = 1;
    step(); chk("ds.exc", excepttype, 14'h0120); chk("ds.pc", current_pc, 32'h8000_0104);
    drain("ds", 32'h8000_0104);

    // Overflow with syscall: overflow only
    ex_insn(32'h8000_0300); ex_overflow = 1; ex_syscall = 1; ex_break = 1;
    step(); chk("ovf.exc", excepttype, 14'h0040);
    drain("ovf", 32'h8000_0300);

    // mtc0 held by stall; no flush
    ex_insn(32'h8000_0400); ex_mtc0 = 1; ex_cp0_addr = 5'b01100;
    step(); chk("mtc0.exc", excepttype, 14'h1801);
    stall = 1; ex_insn(32'h8000_0404); ex_overflow = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mtc0.hold", excepttype, 14'h1801); chk("mtc0.flush", flush_req, 0);
      chk("mtc0.pc", current_pc, 32'h8000_0400);
    end
    stall = 0; ex_idle();
    step(); chk("mtc0.rel", excepttype, 0);

    // eret with stall: one-cycle eret, flush proceeds despite stall; mfc0 gated
    ex_insn(32'h8000_0500); ex_eret = 1; ex_mfc0 = 1; ex_mem_en = 1; ex_mem_size = 2'b10;
    step(); chk("eret.exc", excepttype, 14'h0004); chk("eret.men", mem_en_o, 0);
    stall = 1; ex_insn(32'h8000_0504);
    step(); chk("eret.exc2", excepttype, 0); chk("eret.flush", flush_req, 1);
    step(); chk("eret.drain", flush_req, 0); chk("eret.exc3", excepttype, 0);
    step(); chk("eret.run", flush_req, 0);
    stall = 0; ex_insn(32'h8000_0600);
    step(); chk("eret.resume", current_pc, 32'h8000_0600);

    // Reset during FLUSH aborts the sequence
    ex_insn(32'h8000_0700); ex_invalid = 1;
    step(); chk("rf.exc", excepttype, 14'h0008);
    ex_idle();
    step(); chk("rf.flush", flush_req, 1);
    rst = 1; stall = 1;
    step();
    chk("rf.exc0", excepttype, 0); chk("rf.pc0", current_pc, 0);
    chk("rf.bva0", bad_vaddr, 0);  chk("rf.flush0", flush_req, 0);
    rst = 0; stall = 0; ex_insn(32'h8000_0800);
    step(); chk("rf.run", current_pc, 32'h8000_0800); chk("rf.flush1", flush_req, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
